hilo_ctrl: RTL and testbench
============================

// Module: hilo_ctrl
// PURPOSE
//  Downstream consumer of the Booth multiplier: owns the architectural HI/LO registers.
//  Launches multiplies, waits for the multiplier's completion flag and commits {hi,lo}.
//  Services MFHI/MFLO/MTHI/MTLO and stalls the multicycle CPU control while a multiply is in flight.
//  Runs on posedge clk; the multiplier runs on negedge clk and shares rst.
// PARAMETERS
//  TIMEOUT  64  max WAIT cycles before abort; counter width = $clog2(TIMEOUT+1)
// PORTS
//  clk          in   1   system clock, posedge
//  rst          in   1   reset, synchronous, active-high
//  op_valid     in   1   CPU presents an HI/LO op this cycle
//  op_code      in   3   000 NOP,001 MULT,010 MFHI,011 MFLO,100 MTHI,101 MTLO,110 MADD,111 NOP
//  rs_data      in   32  operand A / MTHI-MTLO write data
//  rt_data      in   32  operand B
//  mul_end      in   1   multiplier done flag (level; cleared by multiplier on start)
//  mul_hi       in   32  multiplier product [63:32]
//  mul_lo       in   32  multiplier product [31:0]
//  mul_start    out  1   one-cycle start pulse to multiplier
//  mul_a        out  32  latched operand A
//  mul_b        out  32  latched operand B
//  rd_data      out  32  MFHI/MFLO result, combinational
//  hi           out  32  architectural HI
//  lo           out  32  architectural LO
//  stall        out  1   CPU must hold op; = op_valid && state!=IDLE
//  busy         out  1   state!=IDLE
//  timeout_err  out  1   sticky, set on WAIT timeout
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, mul_start=0, mul_a=mul_b=0, timeout_err=0, cnt=0, acc flag=0.
//  Ops accepted only at posedge with op_valid && state==IDLE; stalled ops are retried by the CPU.
//  FSM IDLE -> START -> WAIT -> IDLE:
//   IDLE:  MULT/MADD: latch mul_a<=rs_data, mul_b<=rt_data, acc<=(MADD), go START.
//          MTHI: hi<=rs_data. MTLO: lo<=rs_data. Both commit the same edge; stay IDLE.
//          MFHI/MFLO: rd_data=hi/lo in the same cycle, no state change. NOP: nothing.
//   START: mul_start=1 exactly this cycle; the multiplier samples it at the mid-cycle
//          negedge and clears mul_end; cnt<=0; go WAIT.
//   WAIT:  mul_start=0. If mul_end: commit {hi,lo}, go IDLE. Else if cnt==TIMEOUT-1:
//          timeout_err<=1, hi/lo unchanged, go IDLE. Else cnt<=cnt+1.
//  Commit: MULT -> {hi,lo}<={mul_hi,mul_lo}; MADD (see CONFIGURATION) -> accumulate.
//  Latency: MULT accepted at cycle 0 -> START cycle 1 -> WAIT from cycle 2; hi/lo valid
//   the cycle after mul_end is sampled high (~34 cycles total for the 32-step multiplier).
//  rd_data: hi for MFHI, lo for MFLO, else 0; meaningful only when stall=0.
//  Any op while busy: stall=1; no register change. The first MFHI after a MULT returns the new product.
//  A stale mul_end=1 left from the previous op is never sampled: WAIT is entered only after START.
//  rst mid-operation (any state): immediate return to reset values; the multiplier resets on the same rst.
//  timeout_err is cleared by rst only; later ops proceed normally.
// CONFIGURATION
//  HILO_MADD_EN defined: op 110 MADD runs as MULT, commit {hi,lo}<={hi,lo}+{mul_hi,mul_lo},
//   64-bit add, carry out of bit 63 discarded (wrap).
//  HILO_MADD_EN undefined: op 110 decodes as NOP (no stall, no state change); acc logic absent.
// TESTING
//  1 MULT rs=7, rt=0xFFFFFFFD (-3) -> mul_start single pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  2 MULT then MFHI held valid -> stall=1 every cycle until commit; then rd_data=new hi, stall=0.
//  3 MTHI 0x12345678, MTLO 0x9ABCDEF0, MFHI, MFLO -> rd_data=0x12345678, then 0x9ABCDEF0.
//  4 Model never raises mul_end -> timeout_err=1 after 64 WAIT cycles; hi/lo unchanged; busy=0.
//  5 (HILO_MADD_EN) hi=0, lo=0xFFFFFFFF; MADD 1*1 -> hi=1, lo=0; undefined build: op 110 is a no-op.
//  6 rst asserted in WAIT cycle 10 -> next edge: hi=lo=0, busy=0, mul_start=0; fresh MULT 3*4 -> lo=12.

Source files
------------

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: owns architectural HI/LO, launches the Booth multiplier and
// commits its product, services MFHI/MFLO/MTHI/MTLO, stalls the CPU while busy.
// Optional feature macro: HILO_MADD_EN (op 110 = MADD, 64-bit accumulate into {hi,lo}).
// Without it op 110 is a NOP.
module hilo_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mul_end,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_MFHI = 3'b010;
  localparam logic [2:0] OP_MFLO = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
`ifdef HILO_MADD_EN
  localparam logic [2:0] OP_MADD = 3'b110;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;
  logic          accept;
`ifdef HILO_MADD_EN
  logic          acc_q, acc_d;
  logic [63:0]   acc_sum;
`endif

  assign accept = op_valid && (state_q == S_IDLE);
`ifdef HILO_MADD_EN
  // Accumulated product; carry out of bit 63 is dropped (wraps).
  assign acc_sum = {hi_q, lo_q} + {mul_hi, mul_lo};
`endif

  // Next-state and register update logic for the IDLE -> START -> WAIT sequence
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
`ifdef HILO_MADD_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_code)
            OP_MULT: begin
              mul_a_d = rs_data;
              mul_b_d = rt_data;
              state_d = S_START;
`ifdef HILO_MADD_EN
              acc_d   = 1'b0;
`endif
            end
`ifdef HILO_MADD_EN
            OP_MADD: begin
              mul_a_d = rs_data;
              mul_b_d = rt_data;
              acc_d   = 1'b1;
              state_d = S_START;
            end
`endif
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      // mul_start is high only here, so a stale mul_end from the previous
      // product is cleared by the multiplier before WAIT ever samples it.
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_end) begin
`ifdef HILO_MADD_EN
          if (acc_q) begin
            hi_d = acc_sum[63:32];
            lo_d = acc_sum[31:0];
          end else begin
            hi_d = mul_hi;
            lo_d = mul_lo;
          end
`else
          hi_d = mul_hi;
          lo_d = mul_lo;
`endif
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and architectural registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`ifdef HILO_MADD_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`ifdef HILO_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Read port for MFHI/MFLO; only meaningful when the op is not stalled
  always_comb begin
    rd_data = '0;
    if (op_valid && op_code == OP_MFHI) rd_data = hi_q;
    if (op_valid && op_code == OP_MFLO) rd_data = lo_q;
  end

  assign mul_start   = (state_q == S_START);
  assign busy        = (state_q != S_IDLE);
  assign stall       = op_valid && busy;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Testbench for hilo_ctrl: negedge multiplier model plus a HI/LO reference
// model tracked as plain 64-bit arithmetic.
module tb_hilo_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_data, rt_data;
  logic        mul_end;
  logic [31:0] mul_hi, mul_lo;
  logic        mul_start;
  logic [31:0] mul_a, mul_b, rd_data, hi, lo;
  logic        stall, busy, timeout_err;

  int checks = 0;
  int fails  = 0;
  int starts = 0;

  logic [31:0] exp_hi, exp_lo;

  hilo_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .rs_data(rs_data), .rt_data(rt_data), .mul_end(mul_end),
    .mul_hi(mul_hi), .mul_lo(mul_lo), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .rd_data(rd_data), .hi(hi), .lo(lo),
    .stall(stall), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return x * y;
  endfunction

  // Multiplier model: samples mul_start on negedge, result 32 negedges later
  logic        hang;
  int          mcnt;
  logic [63:0] mprod;
  always @(negedge clk) begin
    if (rst) begin
      mul_end <= 1'b0; mcnt <= 0; mul_hi <= '0; mul_lo <= '0;
    end else if (mul_start) begin
      mul_end <= 1'b0; mcnt <= 32; mprod <= smul(mul_a, mul_b);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !hang) begin
        mul_end <= 1'b1;
        {mul_hi, mul_lo} <= mprod;
      end
    end
  end

  always @(negedge clk) if (mul_start) starts++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_code = op; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'b000;
  endtask

  task automatic wait_idle(input int limit, output int cyc);
    cyc = 0;
    while (busy && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (busy) begin
      checks++; fails++;
      $error("FAIL wait_idle_bound observed=busy expected=idle within %0d", limit);
    end
  endtask

  task automatic mult_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int cyc, s0;
    logic [63:0] r;
    s0 = starts;
    issue(op, a, b);
    wait_idle(200, cyc);
    if (op == 3'b001) begin
      r = smul(a, b);
      {exp_hi, exp_lo} = r;
      chk({tag, "_starts"}, 64'(starts - s0), 64'd1);
    end
`ifdef HILO_MADD_EN
    if (op == 3'b110) begin
      r = {exp_hi, exp_lo} + smul(a, b);
      {exp_hi, exp_lo} = r;
      chk({tag, "_starts"}, 64'(starts - s0), 64'd1);
    end
`endif
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  task automatic read_op(input string tag, input logic [2:0] op);
    op_valid = 1'b1; op_code = op; #1;
    chk({tag, "_rd"}, 64'(rd_data), 64'(op == 3'b010 ? exp_hi : exp_lo));
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'b000;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n;
    logic [31:0] a, b;
    rst = 1'b1; op_valid = 1'b0; op_code = 3'b000; rs_data = '0; rt_data = '0; hang = 1'b0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(mul_start), 64'd0);
    chk("rst_ab", {mul_a, mul_b}, 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    rst = 1'b0;

    // MULT 7 * -3
    n = starts;
    issue(3'b001, 32'd7, 32'hFFFF_FFFD);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_ab", {mul_a, mul_b}, {32'd7, 32'hFFFF_FFFD});
    wait_idle(200, cyc);
    chk("t1_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("t1_lo", 64'(lo), 64'hFFFF_FFEB);
    chk("t1_pulses", 64'(starts - n), 64'd1);
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;

    // MTHI/MTLO then reads
    issue(3'b100, 32'h1234_5678, 32'h0);
    chk("t3_mthi", 64'(hi), 64'h1234_5678);
    issue(3'b101, 32'h9ABC_DEF0, 32'h0);
    chk("t3_mtlo", 64'(lo), 64'h9ABC_DEF0);
    exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;
    read_op("t3_mfhi", 3'b010);
    read_op("t3_mflo", 3'b011);

    // MULT followed by MFHI held valid; the stale mul_end must not be sampled
    a = $urandom; b = $urandom;
    issue(3'b001, a, b);
    {exp_hi, exp_lo} = smul(a, b);
    op_valid = 1'b1; op_code = 3'b010; #1;
    n = 0;
    while (busy && n < 200) begin
      chk("t2_stall", 64'(stall), 64'd1);
      chk("t2_hold", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB ^ 64'hFFFF_FFFF_FFFF_FFEB ^ {32'h1234_5678, 32'h9ABC_DEF0});
      @(posedge clk); #1;
      n++;
    end
    chk("t2_stall_end", 64'(stall), 64'd0);
    chk("t2_rd_new_hi", 64'(rd_data), 64'(exp_hi));
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'b000;
    chk("t2_lo", 64'(lo), 64'(exp_lo));

    // op 110
    issue(3'b100, 32'h0, 32'h0);
    issue(3'b101, 32'hFFFF_FFFF, 32'h0);
    exp_hi = 32'h0; exp_lo = 32'hFFFF_FFFF;
`ifdef HILO_MADD_EN
    mult_op("t5_madd", 3'b110, 32'd1, 32'd1);
    chk("t5_hi_abs", 64'(hi), 64'd1);
    chk("t5_lo_abs", 64'(lo), 64'd0);
`else
    n = starts;
    op_valid = 1'b1; op_code = 3'b110; rs_data = 32'd1; rt_data = 32'd1; #1;
    chk("t5_nop_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'b000;
    chk("t5_nop_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("t5_nop_pulses", 64'(starts - n), 64'd0);
    chk("t5_nop_hilo", {hi, lo}, {32'h0, 32'hFFFF_FFFF});
`endif

    // Timeout: multiplier never finishes
    hang = 1'b1;
    issue(3'b001, 32'd11, 32'd13);
    wait_idle(200, cyc);
    chk("t4_cycles", 64'(cyc), 64'(TIMEOUT + 1));
    chk("t4_terr", 64'(timeout_err), 64'd1);
    chk("t4_hilo", {hi, lo}, {exp_hi, exp_lo});
    chk("t4_busy", 64'(busy), 64'd0);
    hang = 1'b0;
    mult_op("t4_after", 3'b001, 32'd5, 32'd6);
    chk("t4_terr_sticky", 64'(timeout_err), 64'd1);

    // Randomized op mix against the reference model
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 6))
        0: mult_op("rnd_mult", 3'b001, a, b);
        1: mult_op("rnd_madd", 3'b110, a, b);
        2: begin issue(3'b100, a, b); exp_hi = a; chk("rnd_mthi", {hi, lo}, {exp_hi, exp_lo}); end
        3: begin issue(3'b101, a, b); exp_lo = a; chk("rnd_mtlo", {hi, lo}, {exp_hi, exp_lo}); end
        4: read_op("rnd_mfhi", 3'b010);
        5: read_op("rnd_mflo", 3'b011);
        default: begin issue(3'b111, a, b); chk("rnd_nop", {hi, lo, 31'd0, busy}, {exp_hi, exp_lo, 32'd0}); end
      endcase
    end

    // Reset in the middle of WAIT
    issue(3'b001, 32'd9, 32'd9);
    repeat (11) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_hi", 64'(hi), 64'd0);
    chk("t6_lo", 64'(lo), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_start", 64'(mul_start), 64'd0);
    chk("t6_terr", 64'(timeout_err), 64'd0);
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    mult_op("t6_fresh", 3'b001, 32'd3, 32'd4);
    chk("t6_lo12", 64'(lo), 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
